// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared state, mode and direction encodings for the LED pattern generator
package led_pattern_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [1:0] MODE_ROL   = 2'd0;
  localparam logic [1:0] MODE_ROR   = 2'd1;
  localparam logic [1:0] MODE_PING  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;
  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;
endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: board-side controls and LED outputs of the pattern generator
interface led_pattern_gen_if #(
  parameter int LED_W  = 8,
  parameter int SEED_W = 3
);
  logic              button;
  logic [1:0]        mode;
  logic [1:0]        speed;
  logic [SEED_W-1:0] seed;
  logic              clear;
  logic [LED_W-1:0]  led;
  logic              running;
  logic              step;
  modport master (output button, mode, speed, seed, clear, input led, running, step);
  modport slave  (input button, mode, speed, seed, clear, output led, running, step);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: synchronises a raw button, filters it and emits a one-cycle pulse per accepted press
module button_debounce #(
  parameter int DEB_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic press
);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0] LAST = DW'(DEB_CYC - 1);
  logic s1, s2, acc;
  logic [DW-1:0] cnt;
  // two-flop synchroniser, then accept a new level once it has persisted DEB_CYC cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      acc <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= button;
      s2 <= s1;
      press <= 1'b0;
      if (s2 == acc) cnt <= '0;
      else if (cnt == LAST) begin
        acc <= s2;
        cnt <= '0;
        press <= s2;
      end else cnt <= cnt + DW'(1);
    end
  end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: button-controlled LED pattern sequencer with selectable mode and step rate
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int LED_W    = 8,
  parameter int SEED_W   = 3,
  parameter int TICK_DIV = 100000000,
  parameter int DEB_CYC  = 1000000
) (
  input logic clk,
  input logic rst_n,
  led_pattern_gen_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW:0] TD  = (CW + 1)'(TICK_DIV);
  localparam logic [CW:0] ONE = (CW + 1)'(1);
  logic press, tick, turn, dir, ndir, running_q, step_q;
  logic [CW-1:0] cnt;
  logic [CW:0] per;
  logic [LED_W-1:0] led_q, seed_ext, rol, ror, nxt;
  state_t state;
  button_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
    .clk(clk),
    .rst_n(rst_n),
    .button(bus.button),
    .press(press)
  );
  assign bus.led = led_q;
  assign bus.running = running_q;
  assign bus.step = step_q;
  // next pattern candidates and the step-due decision for the current speed
  always_comb begin
    seed_ext = LED_W'(bus.seed);
    rol = {led_q[LED_W-2:0], led_q[LED_W-1]};
    ror = {led_q[0], led_q[LED_W-1:1]};
    per = TD >> bus.speed;
    tick = {1'b0, cnt} >= per - ONE;
    turn = (bus.mode == MODE_PING) && (dir == LEFT ? led_q[LED_W-1] : led_q[0]);
    ndir = turn ? ~dir : dir;
    nxt = bus.mode == MODE_ROL ? rol : bus.mode == MODE_ROR ? ror :
          bus.mode == MODE_BLINK ? ~led_q : (ndir == LEFT ? rol : ror);
  end
  // run/pause state machine with the step counter and pattern register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      led_q <= '0;
      running_q <= 1'b0;
      step_q <= 1'b0;
      cnt <= '0;
      dir <= LEFT;
    end else begin
      step_q <= 1'b0;
      if (bus.clear) begin
        state <= IDLE;
        led_q <= seed_ext;
        running_q <= 1'b0;
        cnt <= '0;
        dir <= LEFT;
      end else begin
        case (state)
          IDLE: begin
            led_q <= seed_ext;
            cnt <= '0;
            if (press) begin
              state <= RUN;
              running_q <= 1'b1;
              dir <= LEFT;
            end
          end
          RUN: begin
            if (press) begin
              state <= PAUSE;
              running_q <= 1'b0;
            end else if (tick) begin
              cnt <= '0;
              step_q <= 1'b1;
              led_q <= nxt;
              dir <= ndir;
            end else cnt <= cnt + CW'(1);
          end
          PAUSE: begin
            if (press) begin
              state <= RUN;
              running_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: randomized and directed checks of led_pattern_gen against a behavioural model
module tb_led_pattern_gen;
  localparam int LW = 8, SW = 3, TD = 8, DC = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0, n_bad = 0;
  logic [7:0] m_led;
  logic m_run, m_step, m_dir, m_acc, m_pend;
  int m_state, m_cnt;
  logic h[DC+1];
  led_pattern_gen_if #(.LED_W(LW), .SEED_W(SW)) bus ();
  led_pattern_gen #(.LED_W(LW), .SEED_W(SW), .TICK_DIV(TD), .DEB_CYC(DC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  // one clock of the design plus the model: state 0 idle, 1 running, 2 paused;
  // a press is seen when the last DC synchronised samples all oppose the accepted level
  task automatic clk_step();
    int v;
    bit diff;
    @(posedge clk);
    if (!rst_n) begin
      m_state = 0; m_led = '0; m_run = 0; m_step = 0; m_cnt = 0; m_dir = 0; m_acc = 0; m_pend = 0;
      for (int i = 0; i <= DC; i++) h[i] = 0;
    end else begin
      m_step = 0;
      v = int'(m_led);
      if (bus.clear) begin
        m_state = 0; m_cnt = 0; m_dir = 0; m_led = 8'(bus.seed);
      end else if (m_state == 0) begin
        m_led = 8'(bus.seed);
        m_cnt = 0;
        if (m_pend) begin m_state = 1; m_dir = 0; end
      end else if (m_state == 1) begin
        if (m_pend) m_state = 2;
        else if (m_cnt >= (TD >> bus.speed) - 1) begin
          m_cnt = 0;
          m_step = 1;
          if (bus.mode == 2'd2) begin
            if (m_dir == 0 && v >= 128) m_dir = 1;
            else if (m_dir == 1 && v % 2 == 1) m_dir = 0;
          end
          case (bus.mode)
            2'd0: v = (v * 2) % 256 + v / 128;
            2'd1: v = v / 2 + (v % 2) * 128;
            2'd2: v = m_dir ? v / 2 + (v % 2) * 128 : (v * 2) % 256 + v / 128;
            default: v = 255 - v;
          endcase
          m_led = 8'(v);
        end else m_cnt++;
      end else if (m_pend) m_state = 1;
      m_run = (m_state == 1);
      diff = 1;
      for (int i = 1; i <= DC; i++) if (h[i] == m_acc) diff = 0;
      m_pend = diff && !m_acc;
      if (diff) m_acc = ~m_acc;
      for (int i = DC; i > 0; i--) h[i] = h[i-1];
      h[0] = bus.button;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; bus.button = 0; bus.mode = 0; bus.speed = 0; bus.seed = 3'b101; bus.clear = 0;
    clk_step(); clk_step();
    if (bus.led !== 8'h00 || bus.running !== 1'b0 || bus.step !== 1'b0) begin
      n_bad++; $display("FAIL reset: led=%h run=%b step=%b, want led=00 run=0 step=0", bus.led, bus.running, bus.step);
    end
    n_vec++;
    rst_n = 1;
    clk_step();
    if (bus.led !== 8'h05) begin n_bad++; $display("FAIL reset_seed: led=%h, want 05", bus.led); end
    n_vec++;
    repeat (20) begin
      clk_step();
      if (bus.led !== 8'h05 || bus.running !== 1'b0 || bus.step !== 1'b0) begin
        n_bad++; $display("FAIL idle_hold: led=%h run=%b step=%b, want led=05 run=0 step=0", bus.led, bus.running, bus.step);
      end
      n_vec++;
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] seq [8];
    int c;
    seq = '{8'h0A, 8'h14, 8'h28, 8'h50, 8'hA0, 8'h41, 8'h82, 8'h05};
    bus.mode = 0; bus.speed = 0; bus.button = 1;
    for (int i = 1; i <= 7; i++) begin
      clk_step();
      if (bus.running !== (i == 7)) begin
        n_bad++; $display("FAIL press_latency: cycle %0d running=%b, want %b", i, bus.running, i == 7);
      end
      n_vec++;
    end
    for (int k = 0; k < 8; k++) begin
      c = 0;
      do begin
        clk_step();
        c++;
        if (bus.led !== m_led || bus.running !== m_run || bus.step !== m_step) begin
          n_bad++; $display("FAIL rol_model: led=%h/%h run=%b/%b step=%b/%b (got/want)", bus.led, m_led, bus.running, m_run, bus.step, m_step);
        end
        n_vec++;
      end while (bus.step !== 1'b1 && c < 12);
      if (c != 8 || bus.led !== seq[k]) begin
        n_bad++; $display("FAIL rol_seq: step %0d after %0d cycles led=%h, want 8 cycles led=%h", k, c, bus.led, seq[k]);
      end
      n_vec++;
    end
    bus.button = 0;
    repeat (10) begin
      clk_step();
      if (bus.led !== m_led || bus.running !== 1'b1 || bus.step !== m_step) begin
        n_bad++; $display("FAIL release: led=%h/%h run=%b/1 step=%b/%b (got/want)", bus.led, m_led, bus.running, bus.step, m_step);
      end
      n_vec++;
    end
  endtask

  task automatic test_bounce();
    logic pat [16];
    logic prev;
    int rises;
    for (int i = 0; i < 16; i++) pat[i] = (i == 0 || i == 2 || i >= 4);
    bus.clear = 1; clk_step(); bus.clear = 0;
    repeat (8) clk_step();
    rises = 0; prev = bus.running;
    for (int i = 0; i < 16; i++) begin
      bus.button = pat[i];
      clk_step();
      if (bus.led !== m_led || bus.running !== m_run || bus.step !== m_step) begin
        n_bad++; $display("FAIL bounce_model: led=%h/%h run=%b/%b step=%b/%b (got/want)", bus.led, m_led, bus.running, m_run, bus.step, m_step);
      end
      n_vec++;
      if (bus.running && !prev) rises++;
      prev = bus.running;
    end
    if (rises != 1 || bus.running !== 1'b1) begin
      n_bad++; $display("FAIL bounce_count: presses=%0d running=%b, want 1 and 1", rises, bus.running);
    end
    n_vec++;
    bus.button = 0;
    repeat (10) clk_step();
    for (int i = 0; i < 15; i++) begin
      bus.button = (i < 3);
      clk_step();
      if (bus.running !== 1'b1) begin n_bad++; $display("FAIL glitch: running=%b, want 1", bus.running); end
      n_vec++;
    end
  endtask

  task automatic test_pingpong();
    logic [7:0] seq [15];
    int c;
    seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    bus.clear = 1; bus.seed = 3'b001; bus.mode = 2; bus.speed = 3;
    clk_step();
    bus.clear = 0;
    repeat (8) clk_step();
    bus.button = 1;
    c = 0;
    while (bus.running !== 1'b1 && c < 12) begin clk_step(); c++; end
    if (c != 7 || bus.led !== 8'h01) begin
      n_bad++; $display("FAIL ping_start: %0d cycles led=%h, want 7 cycles led=01", c, bus.led);
    end
    n_vec++;
    for (int k = 0; k < 15; k++) begin
      clk_step();
      if (bus.led !== seq[k] || bus.step !== 1'b1) begin
        n_bad++; $display("FAIL ping_seq: step %0d led=%h step=%b, want led=%h step=1", k, bus.led, bus.step, seq[k]);
      end
      n_vec++;
    end
    bus.button = 0;
  endtask

  task automatic test_pause();
    logic [7:0] held;
    int c;
    bus.clear = 1; bus.seed = 3'b101; bus.mode = 0; bus.speed = 0;
    clk_step();
    bus.clear = 0;
    repeat (8) clk_step();
    bus.button = 1;
    repeat (7) clk_step();
    bus.button = 0;
    repeat (8) clk_step();
    c = 0;
    while (m_cnt != 7 && c < 16) begin clk_step(); c++; end
    if (m_cnt != 7) begin n_bad++; $display("FAIL pause_align: counter=%0d, want 7", m_cnt); end
    n_vec++;
    bus.button = 1;
    repeat (7) clk_step();
    held = bus.led;
    if (bus.running !== 1'b0 || held !== m_led) begin
      n_bad++; $display("FAIL pause_enter: running=%b led=%h, want 0 and %h", bus.running, held, m_led);
    end
    n_vec++;
    bus.button = 0;
    repeat (20) begin
      clk_step();
      if (bus.led !== held || bus.running !== 1'b0 || bus.step !== 1'b0) begin
        n_bad++; $display("FAIL pause_hold: led=%h run=%b step=%b, want led=%h run=0 step=0", bus.led, bus.running, bus.step, held);
      end
      n_vec++;
    end
    bus.button = 1;
    c = 0;
    do begin clk_step(); c++; end while (bus.step !== 1'b1 && c < 16);
    if (c != 10 || bus.running !== 1'b1 || bus.led !== m_led) begin
      n_bad++; $display("FAIL resume: step after %0d cycles run=%b led=%h, want 10 cycles run=1 led=%h", c, bus.running, bus.led, m_led);
    end
    n_vec++;
    bus.button = 0;
  endtask

  task automatic test_speed_blink();
    logic [7:0] prev;
    int c;
    bus.clear = 1; bus.seed = 3'b101; bus.mode = 3; bus.speed = 0;
    clk_step();
    bus.clear = 0;
    repeat (8) clk_step();
    bus.button = 1;
    repeat (7) clk_step();
    c = 0;
    while (m_cnt != 6 && c < 16) begin clk_step(); c++; end
    bus.speed = 3;
    prev = bus.led;
    for (int k = 0; k < 6; k++) begin
      clk_step();
      if (bus.step !== 1'b1 || bus.led !== ~prev || (bus.led !== 8'h05 && bus.led !== 8'hFA)) begin
        n_bad++; $display("FAIL blink_fast: step=%b led=%h, want step=1 led=%h", bus.step, bus.led, ~prev);
      end
      n_vec++;
      prev = bus.led;
    end
    bus.button = 0;
    bus.speed = 0;
  endtask

  task automatic test_clear_press();
    bus.clear = 1; bus.seed = 3'b110;
    clk_step();
    bus.clear = 0;
    repeat (8) clk_step();
    bus.button = 1;
    repeat (6) clk_step();
    bus.clear = 1;
    clk_step();
    bus.clear = 0;
    for (int i = 0; i < 10; i++) begin
      clk_step();
      if (bus.running !== 1'b0 || bus.led !== 8'h06 || bus.step !== 1'b0) begin
        n_bad++; $display("FAIL clear_press: running=%b led=%h step=%b, want 0 06 0", bus.running, bus.led, bus.step);
      end
      n_vec++;
    end
    bus.button = 0;
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin bus.button = 1'($urandom_range(0, 1)); hold = $urandom_range(1, 12); end
      hold--;
      if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) bus.speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) bus.seed = 3'($urandom_range(0, 7));
      bus.clear = ($urandom_range(0, 149) == 0);
      clk_step();
      if (bus.led !== m_led || bus.running !== m_run || bus.step !== m_step) begin
        n_bad++; $display("FAIL random: cycle %0d led=%h/%h run=%b/%b step=%b/%b (got/want)", i, bus.led, m_led, bus.running, m_run, bus.step, m_step);
      end
      n_vec++;
    end
    bus.clear = 0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_pingpong();
    test_pause();
    test_speed_blink();
    test_clear_press();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
